// File: rtl/byte_striping.sv
// Two-lane byte striper: pairs consecutive valid bytes onto lane 0/1 and holds each pair for two clk_2f cycles.
// Optional BYTE_STRIPING_FLUSH_EN flushes an unpaired lane-0 byte after FLUSH_CYCLES idle cycles.
//
// state    | meaning
// ST_LANE0 | next valid byte is a lane-0 byte (captured into hold)
// ST_LANE1 | lane-0 byte pending in hold; next valid byte launches the pair
module byte_striping #(
  parameter int DATA_WIDTH   = 8,
  parameter int FLUSH_CYCLES = 4
) (
  input  logic                  clk_2f,
  input  logic                  reset_L,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  valid_in,
  output logic [DATA_WIDTH-1:0] data_stripe_0,
  output logic [DATA_WIDTH-1:0] data_stripe_1,
  output logic                  valid_stripe_0,
  output logic                  valid_stripe_1,
  output logic                  lane_sel
);

  typedef enum logic {
    ST_LANE0 = 1'b0,
    ST_LANE1 = 1'b1
  } state_t;

  state_t                state, state_nxt;
  logic                  launch, flush;
  logic [DATA_WIDTH-1:0] hold;
  logic [1:0]            timer;

`ifdef BYTE_STRIPING_FLUSH_EN
  logic [3:0] idle_cnt, idle_cnt_nxt;
`endif

  always_ff @(posedge clk_2f or negedge reset_L) begin
    if (!reset_L) state <= ST_LANE0;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    launch    = 1'b0;
    flush     = 1'b0;
`ifdef BYTE_STRIPING_FLUSH_EN
    idle_cnt_nxt = '0;
`endif
    if (state == ST_LANE0) begin
      if (valid_in) state_nxt = ST_LANE1;
    end else begin
      if (valid_in) begin
        launch    = 1'b1;
        state_nxt = ST_LANE0;
      end
`ifdef BYTE_STRIPING_FLUSH_EN
      else begin
        idle_cnt_nxt = (idle_cnt == 4'd15) ? idle_cnt : idle_cnt + 4'd1;
        // flush on the edge the idle count reaches the threshold
        if (idle_cnt_nxt == 4'(FLUSH_CYCLES)) begin
          flush        = 1'b1;
          idle_cnt_nxt = '0;
          state_nxt    = ST_LANE0;
        end
      end
`endif
    end
  end

`ifdef BYTE_STRIPING_FLUSH_EN
  always_ff @(posedge clk_2f or negedge reset_L) begin
    if (!reset_L) idle_cnt <= '0;
    else          idle_cnt <= idle_cnt_nxt;
  end
`endif

  always_ff @(posedge clk_2f or negedge reset_L) begin
    if (!reset_L) begin
      hold           <= '0;
      data_stripe_0  <= '0;
      data_stripe_1  <= '0;
      valid_stripe_0 <= 1'b0;
      valid_stripe_1 <= 1'b0;
      timer          <= 2'd0;
    end else begin
      if (state == ST_LANE0 && valid_in) hold <= data_in;
      if (launch) begin
        data_stripe_0  <= hold;
        data_stripe_1  <= data_in;
        valid_stripe_0 <= 1'b1;
        valid_stripe_1 <= 1'b1;
        timer          <= 2'd2;
      end else if (flush) begin
        data_stripe_0  <= hold;
        valid_stripe_0 <= 1'b1;
        valid_stripe_1 <= 1'b0;
        timer          <= 2'd2;
      end else if (timer != 2'd0) begin
        timer <= timer - 2'd1;
        // data lanes keep their last values; only the valids drop
        if (timer == 2'd1) begin
          valid_stripe_0 <= 1'b0;
          valid_stripe_1 <= 1'b0;
        end
      end
    end
  end

  assign lane_sel = (state == ST_LANE1);

endmodule

// File: tb/tb_byte_striping.sv
// Directed bench for byte_striping: per-cycle vector table plus an asynchronous mid-stream reset sequence.
module tb_byte_striping;

  logic       clk_2f = 1'b0;
  logic       reset_L = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       valid_in = 1'b0;
  logic [7:0] data_stripe_0, data_stripe_1;
  logic       valid_stripe_0, valid_stripe_1, lane_sel;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic       v;
    logic [7:0] d;
    logic [7:0] e0;
    logic [7:0] e1;
    logic       ev0;
    logic       ev1;
    logic       els;
  } vec_t;

  vec_t vecs[$];

  byte_striping #(.DATA_WIDTH(8), .FLUSH_CYCLES(4)) dut (
    .clk_2f        (clk_2f),
    .reset_L       (reset_L),
    .data_in       (data_in),
    .valid_in      (valid_in),
    .data_stripe_0 (data_stripe_0),
    .data_stripe_1 (data_stripe_1),
    .valid_stripe_0(valid_stripe_0),
    .valid_stripe_1(valid_stripe_1),
    .lane_sel      (lane_sel)
  );

  always #5 clk_2f = ~clk_2f;

  task automatic add(input logic v, input logic [7:0] d, input logic [7:0] e0, input logic [7:0] e1,
                     input logic ev0, input logic ev1, input logic els);
    vec_t t;
    t.v = v; t.d = d; t.e0 = e0; t.e1 = e1; t.ev0 = ev0; t.ev1 = ev1; t.els = els;
    vecs.push_back(t);
  endtask

  task automatic chk(input string nm, input int idx, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s[%0d] got=%h want=%h", nm, idx, act, exp);
    end
  endtask

  task automatic chk_all(input string nm, input int idx, input logic [7:0] e0, input logic [7:0] e1,
                         input logic ev0, input logic ev1, input logic els);
    chk({nm, ".d0"}, idx, data_stripe_0, e0);
    chk({nm, ".d1"}, idx, data_stripe_1, e1);
    chk({nm, ".v0"}, idx, {7'd0, valid_stripe_0}, {7'd0, ev0});
    chk({nm, ".v1"}, idx, {7'd0, valid_stripe_1}, {7'd0, ev1});
    chk({nm, ".ls"}, idx, {7'd0, lane_sel}, {7'd0, els});
  endtask

  initial begin
    // back-to-back stream: pairs every 2 cycles, valids continuous
    add(1, 8'hA1, 8'h00, 8'h00, 0, 0, 1);
    add(1, 8'hB2, 8'hA1, 8'hB2, 1, 1, 0);
    add(1, 8'hC3, 8'hA1, 8'hB2, 1, 1, 1);
    add(1, 8'hD4, 8'hC3, 8'hD4, 1, 1, 0);
    add(0, 8'h00, 8'hC3, 8'hD4, 1, 1, 0);
    add(0, 8'h00, 8'hC3, 8'hD4, 0, 0, 0);
    add(0, 8'h00, 8'hC3, 8'hD4, 0, 0, 0);
    // gapped pair
    add(1, 8'h11, 8'hC3, 8'hD4, 0, 0, 1);
    add(0, 8'hEE, 8'hC3, 8'hD4, 0, 0, 1);
    add(0, 8'hEE, 8'hC3, 8'hD4, 0, 0, 1);
    add(0, 8'hEE, 8'hC3, 8'hD4, 0, 0, 1);
    add(1, 8'h22, 8'h11, 8'h22, 1, 1, 0);
    add(0, 8'h00, 8'h11, 8'h22, 1, 1, 0);
    add(0, 8'h00, 8'h11, 8'h22, 0, 0, 0);
`ifdef BYTE_STRIPING_FLUSH_EN
    // 4 idle cycles flush the lone lane-0 byte
    add(1, 8'h55, 8'h11, 8'h22, 0, 0, 1);
    add(0, 8'h00, 8'h11, 8'h22, 0, 0, 1);
    add(0, 8'h00, 8'h11, 8'h22, 0, 0, 1);
    add(0, 8'h00, 8'h11, 8'h22, 0, 0, 1);
    add(0, 8'h00, 8'h55, 8'h22, 1, 0, 0);
    add(0, 8'h00, 8'h55, 8'h22, 1, 0, 0);
    add(0, 8'h00, 8'h55, 8'h22, 0, 0, 0);
    add(1, 8'h66, 8'h55, 8'h22, 0, 0, 1);
    add(1, 8'h67, 8'h66, 8'h67, 1, 1, 0);
    // valid on the threshold cycle wins over flush
    add(1, 8'h55, 8'h66, 8'h67, 1, 1, 1);
    add(0, 8'h00, 8'h66, 8'h67, 0, 0, 1);
    add(0, 8'h00, 8'h66, 8'h67, 0, 0, 1);
    add(0, 8'h00, 8'h66, 8'h67, 0, 0, 1);
    add(1, 8'h77, 8'h55, 8'h77, 1, 1, 0);
`else
    // no flush: lone lane-0 byte waits through a long gap
    add(1, 8'h55, 8'h11, 8'h22, 0, 0, 1);
    add(0, 8'h00, 8'h11, 8'h22, 0, 0, 1);
    add(0, 8'h00, 8'h11, 8'h22, 0, 0, 1);
    add(0, 8'h00, 8'h11, 8'h22, 0, 0, 1);
    add(0, 8'h00, 8'h11, 8'h22, 0, 0, 1);
    add(0, 8'h00, 8'h11, 8'h22, 0, 0, 1);
    add(0, 8'h00, 8'h11, 8'h22, 0, 0, 1);
    add(1, 8'h66, 8'h55, 8'h66, 1, 1, 0);
`endif

    // reset state
    repeat (2) @(posedge clk_2f);
    #1 chk_all("reset", 0, 8'h00, 8'h00, 0, 0, 0);
    @(negedge clk_2f);
    reset_L = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      valid_in = vecs[i].v;
      data_in  = vecs[i].d;
      @(posedge clk_2f);
      #1 chk_all("vec", i, vecs[i].e0, vecs[i].e1, vecs[i].ev0, vecs[i].ev1, vecs[i].els);
      @(negedge clk_2f);
    end

    // async reset between edges after a pending lane-0 byte
    valid_in = 1'b1;
    data_in  = 8'h9A;
    @(posedge clk_2f);
    #1 chk("pend9a.ls", 0, {7'd0, lane_sel}, 8'h01);
    #2 reset_L = 1'b0;
    #1 chk_all("asyncrst", 0, 8'h00, 8'h00, 0, 0, 0);
    valid_in = 1'b0;
    @(negedge clk_2f);
    reset_L  = 1'b1;
    valid_in = 1'b1;
    data_in  = 8'h01;
    @(posedge clk_2f);
    #1 chk_all("post01", 0, 8'h00, 8'h00, 0, 0, 1);
    @(negedge clk_2f);
    data_in = 8'h02;
    @(posedge clk_2f);
    #1 chk_all("post02", 0, 8'h01, 8'h02, 1, 1, 0);
    @(negedge clk_2f);
    valid_in = 1'b0;
    repeat (2) @(posedge clk_2f);
    #1 chk_all("postidle", 0, 8'h01, 8'h02, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
